fm_coef_align: RTL and testbench
================================

// Module: fm_coef_align
// PURPOSE
// Sits directly downstream of the first-stage feature statistics (mean/variance)
// unit in the HFN datapath. It buffers one frame of N-lane fp16 feature beats
// while that unit computes the per-frame coefficients (scale = 1/var or
// 1/sqrt(var), offset = mean/var). It then replays the frame with the coefficients
// attached to every beat, feeding the fp16 multiply-subtract normalisation stage.
// PARAMETERS
// bitwidth  16  width of one fp16 lane / coefficient
// N         8   lanes per beat
// DEPTH     64  frame buffer depth in beats, power of 2, >=2
// AW        $clog2(DEPTH)  buffer address width (derived, do not override)
// PORTS
// clk         in   1           clock
// rstn        in   1           asynchronous active-low reset
// mode        in   1           0: y=x*a-b ; 1: y=x*a, b forced to 0 (sampled at coef capture)
// x_in        in   N*bitwidth  feature beat
// x_in_valid  in   1           beat valid
// x_in_last   in   1           last beat of frame
// x_in_ready  out  1           beat accepted when valid&ready
// coef_a      in   bitwidth    scale (first-stage one_variance_out)
// coef_b      in   bitwidth    offset (first-stage mean_variance_out)
// coef_valid  in   1           coefficient valid
// coef_last   in   1           coefficient final; capture only on valid&last
// m_x         out  N*bitwidth  replayed beat
// m_a         out  bitwidth    scale for this frame
// m_b         out  bitwidth    offset for this frame (0 if mode=1)
// m_valid     out  1           output valid
// m_last      out  1           last replayed beat of frame
// m_ready     in   1           downstream ready
// overflow    out  1           sticky: frame exceeded DEPTH beats
// coef_err    out  1           sticky: coefficient arrived while one already pending
// BEHAVIOUR
// - Reset (async): state=FILL, wr/rd ptr=0, count=0, coef_pend=0. All outputs 0,
//   except x_in_ready=1. overflow and coef_err are 0 and are cleared only by reset.
// - Buffer: circular, AW-bit ptrs wrap at DEPTH; count 0..DEPTH; simultaneous
//   write+read leaves count unchanged.
// - FSM FILL: x_in_ready=1. Each valid beat is written if count<DEPTH; if full,
//   the beat is discarded and overflow is set. An accepted beat with x_in_last
//   goes to WAIT when coef_pend=0, else directly to DRAIN.
//   An empty-frame last is still a frame.
// - FSM WAIT: x_in_ready=0; on coef capture go to DRAIN next cycle.
// - FSM DRAIN: x_in_ready=0. The output register loads when (!m_valid||m_ready) and
//   count>0. m_last=1 on the beat that empties the buffer. When the m_last beat is
//   accepted (m_valid&m_ready&m_last), clear coef_pend and go to FILL. A frame
//   with zero stored beats emits nothing and returns to FILL.
// - Coef capture: coef_valid&coef_last while coef_pend=0, in any state. Latch a,
//   latch b (or 0 if mode=1), set coef_pend. If coef_pend=1, ignore the value and
//   set coef_err.
// - Latency: capture in cycle T with frame complete -> DRAIN at T+1 -> first
//   m_valid at T+2. Throughput is 1 beat/cycle with m_ready held high.
// - Handshake: while m_valid&!m_ready, m_x/m_a/m_b/m_last are held stable.
//   m_valid never drops without acceptance.
// - m_a/m_b stay constant for the whole frame; new coefficients never alter an
//   in-flight frame.
// - Reset mid-frame discards the buffer and pending coefficients. There is no
//   partial output after reset.
// TESTING
// 1 frame of 4 beats (lane k of beat i = i*8+k), then coef a=16'h3C00, b=16'h3800,
//   mode=0 -> 4 beats out in order, a/b on each, m_last only on beat 3, m_valid 2 cyc after coef.
// 2 coef captured mid-FILL, before last -> DRAIN the cycle after the last beat. Same mode=1
//   case -> m_b=0.
// 3 DEPTH+3 beats with last -> overflow=1, exactly DEPTH beats out, m_last on the DEPTH-th.
// 4 m_ready toggled 1,0,0,1 during DRAIN -> outputs held stable while stalled, no beat
//   lost or duplicated.
// 5 second coef_valid&last while pending -> coef_err=1, first a/b used for the frame.
// 6 rstn low mid-DRAIN, then a new 2-beat frame -> only the new frame's 2 beats out,
//   x_in_ready=1 after reset.

Source files
------------

// File: rtl/fm_coef_align.sv
// fm_coef_align
//   Buffers one frame of N-lane fp16 feature beats while the upstream
//   statistics unit computes the per-frame scale/offset coefficients, then
//   replays the frame with those coefficients attached to every beat.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   mode                   0: y=x*a-b, 1: y=x*a (b forced to 0), sampled at capture
//   x_in / _valid / _last  incoming feature beats, x_in_ready accepts them
//   coef_a / coef_b        scale / offset, captured on coef_valid & coef_last
//   m_x / m_a / m_b        replayed beat with its frame coefficients
//   m_valid / m_last       output handshake, m_ready from downstream
//   overflow               sticky: a frame exceeded DEPTH beats
//   coef_err               sticky: coefficient arrived while one was pending
module fm_coef_align #(
  parameter int bitwidth = 16,
  parameter int N        = 8,
  parameter int DEPTH    = 64,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    mode,
  input  logic [N*bitwidth-1:0]   x_in,
  input  logic                    x_in_valid,
  input  logic                    x_in_last,
  output logic                    x_in_ready,
  input  logic [bitwidth-1:0]     coef_a,
  input  logic [bitwidth-1:0]     coef_b,
  input  logic                    coef_valid,
  input  logic                    coef_last,
  output logic [N*bitwidth-1:0]   m_x,
  output logic [bitwidth-1:0]     m_a,
  output logic [bitwidth-1:0]     m_b,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic                    overflow,
  output logic                    coef_err
);

  typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_t;

  state_t state, state_nxt;

  logic [N*bitwidth-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  coef_pend;
  logic [bitwidth-1:0]   a_q, b_q;

  logic full, beat_in, wr_en, rd_en;
  logic coef_hit, coef_cap, drain_done;

  assign full       = (count == (AW+1)'(DEPTH));
  assign beat_in    = (state == FILL) && x_in_valid;
  assign wr_en      = beat_in && !full;
  assign rd_en      = (state == DRAIN) && (!m_valid || m_ready) && (count != '0);
  assign coef_hit   = coef_valid && coef_last;
  assign coef_cap   = coef_hit && !coef_pend;
  // A frame ends either when its last beat is accepted downstream or when
  // it stored nothing at all (no beat will ever be presented).
  assign drain_done = (state == DRAIN) &&
                      ((m_valid && m_ready && m_last) || (count == '0 && !m_valid));
  assign x_in_ready = (state == FILL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= FILL;
    else       state <= state_nxt;
  end

  // WAIT also honours an already-pending coefficient, which covers a capture
  // landing in the same cycle as the frame's last beat.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (x_in_valid && x_in_last) state_nxt = coef_pend ? DRAIN : WAIT;
      WAIT:    if (coef_cap || coef_pend)   state_nxt = DRAIN;
      DRAIN:   if (drain_done)              state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= x_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (beat_in && full) overflow <= 1'b1;
    end
  end

  // Coefficients are held until the frame using them has fully drained, so
  // a second arrival in that window is reported and dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      coef_pend <= 1'b0;
      coef_err  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      if (coef_cap) begin
        coef_pend <= 1'b1;
        a_q       <= coef_a;
        b_q       <= mode ? '0 : coef_b;
      end else if (drain_done) begin
        coef_pend <= 1'b0;
      end
      if (coef_hit && coef_pend) coef_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_x     <= '0;
      m_a     <= '0;
      m_b     <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      if (rd_en) begin
        m_x     <= mem[rd_ptr];
        m_a     <= a_q;
        m_b     <= b_q;
        m_valid <= 1'b1;
        m_last  <= (count == (AW+1)'(1));
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fm_coef_align.sv
// tb_fm_coef_align
//   Directed self-checking bench for fm_coef_align: frame replay, early
//   coefficient, overflow, back-pressure, duplicate coefficient and reset.
module tb_fm_coef_align;

  localparam int BW    = 16;
  localparam int N     = 8;
  localparam int DEPTH = 64;

  logic           clk;
  logic           rstn;
  logic           mode;
  logic [N*BW-1:0] x_in;
  logic           x_in_valid;
  logic           x_in_last;
  logic           x_in_ready;
  logic [BW-1:0]  coef_a;
  logic [BW-1:0]  coef_b;
  logic           coef_valid;
  logic           coef_last;
  logic [N*BW-1:0] m_x;
  logic [BW-1:0]  m_a;
  logic [BW-1:0]  m_b;
  logic           m_valid;
  logic           m_last;
  logic           m_ready;
  logic           overflow;
  logic           coef_err;

  fm_coef_align #(.bitwidth(BW), .N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .mode(mode),
    .x_in(x_in), .x_in_valid(x_in_valid), .x_in_last(x_in_last), .x_in_ready(x_in_ready),
    .coef_a(coef_a), .coef_b(coef_b), .coef_valid(coef_valid), .coef_last(coef_last),
    .m_x(m_x), .m_a(m_a), .m_b(m_b), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .overflow(overflow), .coef_err(coef_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N*BW-1:0] got_x[$];
  logic [BW-1:0]   got_a[$];
  logic [BW-1:0]   got_b[$];
  logic            got_last[$];

  logic            hold_pending = 1'b0;
  logic [N*BW-1:0] hold_x;
  logic [BW-1:0]   hold_a, hold_b;
  logic            hold_last;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [N*BW-1:0] beatVal(input int base, input int i);
    logic [N*BW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*BW +: BW] = 16'(base + i*8 + k);
    return v;
  endfunction

  // Called just after a falling edge: records a beat the coming rising edge
  // accepts and checks that a stalled beat stayed put, then advances a cycle.
  task automatic stepCycle();
    if (hold_pending) begin
      checkOutput("hold_valid", 128'(m_valid), 128'(1));
      checkOutput("hold_x", 128'(m_x), 128'(hold_x));
      checkOutput("hold_a", 128'(m_a), 128'(hold_a));
      checkOutput("hold_b", 128'(m_b), 128'(hold_b));
      checkOutput("hold_last", 128'(m_last), 128'(hold_last));
    end
    hold_pending = m_valid && !m_ready;
    hold_x = m_x; hold_a = m_a; hold_b = m_b; hold_last = m_last;
    if (m_valid && m_ready) begin
      got_x.push_back(m_x);
      got_a.push_back(m_a);
      got_b.push_back(m_b);
      got_last.push_back(m_last);
    end
    @(negedge clk);
  endtask

  task automatic clearQueues();
    got_x.delete(); got_a.delete(); got_b.delete(); got_last.delete();
  endtask

  // Drives a frame of n beats; a coefficient rides along on beat coef_at (-1: none).
  task automatic applyStimulus(input int n, input int base, input int coef_at,
                               input logic [BW-1:0] a, input logic [BW-1:0] b, input logic md);
    for (int i = 0; i < n; i++) begin
      x_in       = beatVal(base, i);
      x_in_valid = 1'b1;
      x_in_last  = (i == n-1);
      coef_valid = (i == coef_at);
      coef_last  = (i == coef_at);
      coef_a     = a;
      coef_b     = b;
      mode       = md;
      stepCycle();
    end
    x_in_valid = 1'b0;
    x_in_last  = 1'b0;
    coef_valid = 1'b0;
    coef_last  = 1'b0;
  endtask

  task automatic sendCoef(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic md);
    coef_a = a; coef_b = b; mode = md;
    coef_valid = 1'b1; coef_last = 1'b1;
    stepCycle();
    coef_valid = 1'b0; coef_last = 1'b0;
  endtask

  // pat bit j is m_ready for the j-th cycle in which a beat is on offer.
  task automatic drainAll(input int nexp, input logic [15:0] pat);
    int j;
    int budget;
    j = 0;
    budget = 0;
    while (got_x.size() < nexp && budget < 300) begin
      if (m_valid) begin
        m_ready = (j < 16) ? pat[j] : 1'b1;
        j++;
      end else begin
        m_ready = 1'b1;
      end
      stepCycle();
      budget++;
    end
    m_ready = 1'b1;
    repeat (4) stepCycle();
  endtask

  task automatic checkFrame(input string tag, input int base, input int n,
                            input logic [BW-1:0] a, input logic [BW-1:0] b);
    checkOutput({tag, "_count"}, 128'(got_x.size()), 128'(n));
    for (int i = 0; i < n && i < got_x.size(); i++) begin
      checkOutput({tag, "_x"}, 128'(got_x[i]), 128'(beatVal(base, i)));
      checkOutput({tag, "_a"}, 128'(got_a[i]), 128'(a));
      checkOutput({tag, "_b"}, 128'(got_b[i]), 128'(b));
      checkOutput({tag, "_last"}, 128'(got_last[i]), 128'(i == n-1));
    end
  endtask

  initial begin
    rstn = 1'b0; mode = 1'b0; x_in = '0; x_in_valid = 1'b0; x_in_last = 1'b0;
    coef_a = '0; coef_b = '0; coef_valid = 1'b0; coef_last = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_x_in_ready", 128'(x_in_ready), 128'(1));
    checkOutput("rst_m_valid", 128'(m_valid), 128'(0));
    checkOutput("rst_m_last", 128'(m_last), 128'(0));
    checkOutput("rst_m_x", 128'(m_x), 128'(0));
    checkOutput("rst_m_a", 128'(m_a), 128'(0));
    checkOutput("rst_overflow", 128'(overflow), 128'(0));
    checkOutput("rst_coef_err", 128'(coef_err), 128'(0));
    rstn = 1'b1;
    stepCycle();

    // 1: 4-beat frame, then coefficients; two-cycle latency to first beat
    clearQueues();
    applyStimulus(4, 0, -1, '0, '0, 1'b0);
    checkOutput("t1_wait_ready", 128'(x_in_ready), 128'(0));
    sendCoef(16'h3C00, 16'h3800, 1'b0);
    checkOutput("t1_lat_t1", 128'(m_valid), 128'(0));
    stepCycle();
    checkOutput("t1_lat_t2", 128'(m_valid), 128'(1));
    drainAll(4, 16'hFFFF);
    checkFrame("t1", 0, 4, 16'h3C00, 16'h3800);
    checkOutput("t1_back_to_fill", 128'(x_in_ready), 128'(1));

    // 2: coefficient during FILL, drain starts right after the last beat
    clearQueues();
    applyStimulus(3, 16'h40, 1, 16'h4000, 16'h3555, 1'b0);
    checkOutput("t2_drain_ready", 128'(x_in_ready), 128'(0));
    checkOutput("t2_lat_l1", 128'(m_valid), 128'(0));
    stepCycle();
    checkOutput("t2_lat_l2", 128'(m_valid), 128'(1));
    drainAll(3, 16'hFFFF);
    checkFrame("t2", 16'h40, 3, 16'h4000, 16'h3555);
    clearQueues();
    applyStimulus(3, 16'h60, 1, 16'h4200, 16'h3555, 1'b1);
    drainAll(3, 16'hFFFF);
    checkFrame("t2m1", 16'h60, 3, 16'h4200, 16'h0000);
    checkOutput("t2_no_overflow", 128'(overflow), 128'(0));

    // 3: DEPTH+3 beats overflow the buffer; only DEPTH come back out
    clearQueues();
    applyStimulus(DEPTH + 3, 16'h1000, -1, '0, '0, 1'b0);
    checkOutput("t3_overflow", 128'(overflow), 128'(1));
    sendCoef(16'h3A00, 16'h3100, 1'b0);
    drainAll(DEPTH, 16'hFFFF);
    checkFrame("t3", 16'h1000, DEPTH, 16'h3A00, 16'h3100);

    // 4: back-pressure 1,0,0,1 while draining
    clearQueues();
    applyStimulus(3, 16'h2000, -1, '0, '0, 1'b0);
    sendCoef(16'h3E00, 16'h3300, 1'b0);
    drainAll(3, 16'hFFF9);
    checkFrame("t4", 16'h2000, 3, 16'h3E00, 16'h3300);

    // 5: duplicate coefficient while pending is flagged and ignored
    clearQueues();
    checkOutput("t5_err_before", 128'(coef_err), 128'(0));
    applyStimulus(2, 16'h100, -1, '0, '0, 1'b0);
    sendCoef(16'h4400, 16'h3000, 1'b0);
    sendCoef(16'h4800, 16'h3F00, 1'b0);
    checkOutput("t5_coef_err", 128'(coef_err), 128'(1));
    drainAll(2, 16'hFFFF);
    checkFrame("t5", 16'h100, 2, 16'h4400, 16'h3000);

    // 6: reset in the middle of a drain, then a fresh 2-beat frame
    clearQueues();
    applyStimulus(4, 16'h200, -1, '0, '0, 1'b0);
    sendCoef(16'h3C00, 16'h3800, 1'b0);
    m_ready = 1'b0;
    begin
      int guard;
      guard = 0;
      while (!m_valid && guard < 20) begin
        stepCycle();
        guard++;
      end
      checkOutput("t6_mid_drain_valid", 128'(m_valid), 128'(1));
    end
    rstn = 1'b0;
    @(negedge clk);
    hold_pending = 1'b0;
    checkOutput("t6_rst_ready", 128'(x_in_ready), 128'(1));
    checkOutput("t6_rst_valid", 128'(m_valid), 128'(0));
    checkOutput("t6_rst_overflow", 128'(overflow), 128'(0));
    checkOutput("t6_rst_coef_err", 128'(coef_err), 128'(0));
    rstn = 1'b1;
    m_ready = 1'b1;
    clearQueues();
    stepCycle();
    checkOutput("t6_after_rst_valid", 128'(m_valid), 128'(0));
    applyStimulus(2, 16'h300, -1, '0, '0, 1'b0);
    sendCoef(16'h3D00, 16'h3900, 1'b0);
    drainAll(2, 16'hFFFF);
    checkFrame("t6", 16'h300, 2, 16'h3D00, 16'h3900);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
